lc3b_cache: RTL

- Parametrised direct-mapped, write-back, write-allocate cache for the LC-3b multicycle CPU.
- Sits between the CPU's word-wide memory port (mem_*) and physical memory's line-wide port (pmem_*).
- CPU-side handshake is unchanged: the CPU holds mem_read or mem_write until mem_resp.
- Adds byte-masked writes, dirty tracking and line write-back.

---
 rtl/lc3b_cache_pkg.sv | 13 +
 rtl/lc3b_cache_control.sv | 84 ++++++++
 rtl/lc3b_cache_datapath.sv | 99 +++++++++
 rtl/lc3b_cache.sv | 70 +++++++
 4 files changed

// File: rtl/lc3b_cache_pkg.sv
// Shared types for the LC-3b direct-mapped write-back cache.
package lc3b_cache_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WRITEBACK = 2'b01,
        ALLOCATE  = 2'b10
    } cache_state_t;

endpackage

// File: rtl/lc3b_cache_control.sv
// Cache FSM: CPU handshake, physical-memory request sequencing and
// the strobes that tell the datapath when to update its arrays.
module lc3b_cache_control
    import lc3b_cache_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic mem_read,
    input  logic mem_write,
    input  logic hit,
    input  logic victim_dirty,
    input  logic pmem_resp,
    output logic mem_resp,
    output logic pmem_read,
    output logic pmem_write,
    output logic write_hit,
    output logic load_line,
    output logic clear_dirty,
    output logic latch_addr,
    output logic wb_sel
);

    cache_state_t state;
    logic         req;

    assign req = mem_read | mem_write;

    // State register; pmem strobes are registered alongside the state so they
    // rise on entry to a miss state and fall on the edge that consumes pmem_resp.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && !hit) begin
                        if (victim_dirty) begin
                            state      <= WRITEBACK;
                            pmem_write <= 1'b1;
                        end else begin
                            state     <= ALLOCATE;
                            pmem_read <= 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        pmem_write <= 1'b0;
                        // A dropped request finishes the write-back but skips the fill.
                        if (req) begin
                            state     <= ALLOCATE;
                            pmem_read <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                ALLOCATE: begin
                    if (pmem_resp) begin
                        pmem_read <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    pmem_read  <= 1'b0;
                    pmem_write <= 1'b0;
                end
            endcase
        end
    end

    // Hits complete in the cycle they are presented, so mem_resp is decoded
    // combinationally; everything is gated by reset so nothing commits then.
    assign mem_resp    = rst_n && (state == IDLE) && req && hit;
    assign write_hit   = mem_resp && mem_write;
    assign load_line   = rst_n && (state == ALLOCATE) && pmem_resp;
    assign clear_dirty = rst_n && (state == WRITEBACK) && pmem_resp;
    assign latch_addr  = (state == IDLE);
    assign wb_sel      = (state == WRITEBACK);

endmodule

// File: rtl/lc3b_cache_datapath.sv
// Cache storage (valid/dirty/tag/line flops), tag compare, byte-merge for
// write hits and the physical-memory address mux.
module lc3b_cache_datapath
    import lc3b_cache_pkg::*;
#(
    parameter int SETS           = 8,
    parameter int WORDS_PER_LINE = 8,
    parameter int ADDR_WIDTH     = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_WIDTH-1:0]        mem_address,
    input  logic [15:0]                  mem_wdata,
    input  logic [1:0]                   mem_byte_enable,
    input  logic                         write_hit,
    input  logic                         load_line,
    input  logic                         clear_dirty,
    input  logic                         latch_addr,
    input  logic                         wb_sel,
    input  logic [16*WORDS_PER_LINE-1:0] pmem_rdata,
    output logic                         hit,
    output logic                         victim_dirty,
    output logic [15:0]                  mem_rdata,
    output logic [ADDR_WIDTH-1:0]        pmem_address,
    output logic [16*WORDS_PER_LINE-1:0] pmem_wdata
);

    localparam int LINE_WIDTH = 16 * WORDS_PER_LINE;
    localparam int OFF_BITS   = $clog2(2 * WORDS_PER_LINE);
    localparam int IDX_BITS   = $clog2(SETS);
    localparam int TAG_BITS   = ADDR_WIDTH - OFF_BITS - IDX_BITS;

    logic [LINE_WIDTH-1:0] line_arr [SETS];
    logic [TAG_BITS-1:0]   tag_arr  [SETS];
    logic [SETS-1:0]       valid;
    logic [SETS-1:0]       dirty;

    logic [TAG_BITS-1:0]   tag;
    logic [IDX_BITS-1:0]   idx;
    logic [OFF_BITS-2:0]   word;
    logic                  unused_byte_bit;

    // Line address of the request that caused the miss, held while the FSM
    // talks to physical memory so pmem_address cannot move under it.
    logic [ADDR_WIDTH-OFF_BITS-1:0] q_line;
    logic [TAG_BITS-1:0]            q_tag;
    logic [IDX_BITS-1:0]            q_idx;

    lc3b_word      cur_word;
    lc3b_word      merged_word;
    lc3b_mem_wmask be;

    assign tag             = mem_address[ADDR_WIDTH-1:OFF_BITS+IDX_BITS];
    assign idx             = mem_address[OFF_BITS+IDX_BITS-1:OFF_BITS];
    assign word            = mem_address[OFF_BITS-1:1];
    assign unused_byte_bit = mem_address[0];
    assign q_tag           = q_line[ADDR_WIDTH-OFF_BITS-1:IDX_BITS];
    assign q_idx           = q_line[IDX_BITS-1:0];
    assign be              = mem_byte_enable;

    assign hit          = valid[idx] && (tag_arr[idx] == tag);
    assign victim_dirty = valid[idx] && dirty[idx];
    assign cur_word     = line_arr[idx][{word, 4'b0000} +: 16];
    assign mem_rdata    = cur_word;
    assign merged_word  = {be[1] ? mem_wdata[15:8] : cur_word[15:8],
                           be[0] ? mem_wdata[7:0]  : cur_word[7:0]};

    assign pmem_address = wb_sel ? {tag_arr[q_idx], q_idx, {OFF_BITS{1'b0}}}
                                 : {q_tag,          q_idx, {OFF_BITS{1'b0}}};
    assign pmem_wdata   = line_arr[q_idx];

    // Data, tag and captured address carry no reset: only valid/dirty matter.
    always_ff @(posedge clk) begin
        if (latch_addr)
            q_line <= mem_address[ADDR_WIDTH-1:OFF_BITS];
        if (load_line) begin
            line_arr[q_idx] <= pmem_rdata;
            tag_arr[q_idx]  <= q_tag;
        end else if (write_hit) begin
            line_arr[idx][{word, 4'b0000} +: 16] <= merged_word;
        end
    end

    // Valid/dirty bookkeeping; reset invalidates every line and drops dirty data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
            dirty <= '0;
        end else if (load_line) begin
            valid[q_idx] <= 1'b1;
            dirty[q_idx] <= 1'b0;
        end else if (clear_dirty) begin
            dirty[q_idx] <= 1'b0;
        end else if (write_hit && (be != 2'b00)) begin
            dirty[idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/lc3b_cache.sv
// Direct-mapped write-back, write-allocate cache between the LC-3b CPU
// word port and the line-wide physical memory port. Thin wrapper only.
module lc3b_cache
    import lc3b_cache_pkg::*;
#(
    parameter int SETS           = 8,
    parameter int WORDS_PER_LINE = 8,
    parameter int ADDR_WIDTH     = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         mem_read,
    input  logic                         mem_write,
    input  logic [1:0]                   mem_byte_enable,
    input  logic [ADDR_WIDTH-1:0]        mem_address,
    input  logic [15:0]                  mem_wdata,
    output logic [15:0]                  mem_rdata,
    output logic                         mem_resp,
    output logic                         pmem_read,
    output logic                         pmem_write,
    output logic [ADDR_WIDTH-1:0]        pmem_address,
    output logic [16*WORDS_PER_LINE-1:0] pmem_wdata,
    input  logic [16*WORDS_PER_LINE-1:0] pmem_rdata,
    input  logic                         pmem_resp
);

    logic hit, victim_dirty, write_hit, load_line, clear_dirty, latch_addr, wb_sel;

    lc3b_cache_control u_control (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .hit          (hit),
        .victim_dirty (victim_dirty),
        .pmem_resp    (pmem_resp),
        .mem_resp     (mem_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .write_hit    (write_hit),
        .load_line    (load_line),
        .clear_dirty  (clear_dirty),
        .latch_addr   (latch_addr),
        .wb_sel       (wb_sel)
    );

    lc3b_cache_datapath #(
        .SETS           (SETS),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .ADDR_WIDTH     (ADDR_WIDTH)
    ) u_datapath (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .write_hit       (write_hit),
        .load_line       (load_line),
        .clear_dirty     (clear_dirty),
        .latch_addr      (latch_addr),
        .wb_sel          (wb_sel),
        .pmem_rdata      (pmem_rdata),
        .hit             (hit),
        .victim_dirty    (victim_dirty),
        .mem_rdata       (mem_rdata),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata)
    );

endmodule
